// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between two burst clients.
// Define SDRAM_ARBITER_REFRESH_EN to add periodic auto-refresh scheduling between grants.
module sdram_arbiter #(
    parameter int unsigned RamAddressBitWidth = 21,
    parameter int unsigned RefreshInterval    = 1560,
    parameter int unsigned RefreshGap         = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [1:0]                          req,
    output logic [1:0]                          gnt,
    input  logic [1:0]                          c_cmd_en,
    input  logic [1:0][2:0]                     c_cmd,
    input  logic [1:0][RamAddressBitWidth-1:0]  c_addr,
    input  logic [1:0][7:0]                     c_data_len,
    input  logic [1:0][31:0]                    c_data,
    output logic [1:0]                          c_cmd_ack,
    output logic                                I_sdrc_cmd_en,
    output logic [2:0]                          I_sdrc_cmd,
    output logic [RamAddressBitWidth-1:0]       I_sdrc_addr,
    output logic [7:0]                          I_sdrc_data_len,
    output logic [31:0]                         I_sdrc_data,
    input  logic                                O_sdrc_init_done,
    input  logic                                O_sdrc_cmd_ack,
    output logic                                refresh_overrun
);

    localparam logic [2:0] StInit    = 3'd0;
    localparam logic [2:0] StIdle    = 3'd1;
    localparam logic [2:0] StGrant   = 3'd2;
    localparam logic [2:0] StRefresh = 3'd3;

    logic [2:0] state_q, state_d;
    // Holds the current owner while in Grant and the previous owner while Idle.
    logic       last_grant_q, last_grant_d;
    logic       refresh_due;

`ifdef SDRAM_ARBITER_REFRESH_EN
    localparam logic [2:0]  StRefreshWait = 3'd4;
    localparam logic [2:0]  StRefreshGap  = 3'd5;
    localparam int unsigned CntW = (RefreshInterval > 1) ? $clog2(RefreshInterval) : 1;
    localparam int unsigned GapW = (RefreshGap > 1) ? $clog2(RefreshGap) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(RefreshInterval - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(RefreshGap - 1);

    logic [CntW-1:0] cnt_q;
    logic [GapW-1:0] gap_q, gap_d;
    logic            pend_q, overrun_q, wrap;

    assign wrap = (state_q != StInit) && (cnt_q == CntLast);
    // A wrap seen in Idle counts as pending so refresh beats a same-cycle request.
    assign refresh_due = pend_q | wrap;
    assign refresh_overrun = overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            gap_q     <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            gap_q <= gap_d;
            if (state_q != StInit) begin
                cnt_q <= wrap ? '0 : cnt_q + CntW'(1);
            end
            if (wrap) begin
                pend_q <= 1'b1;
            end else if (state_q == StRefresh) begin
                pend_q <= 1'b0;
            end
            if (wrap && pend_q && (state_q != StRefresh)) begin
                overrun_q <= 1'b1;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg      = ^{RefreshInterval, RefreshGap};
    assign refresh_due     = 1'b0;
    assign refresh_overrun = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StInit;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
`ifdef SDRAM_ARBITER_REFRESH_EN
        gap_d        = gap_q;
`endif
        case (state_q)
            StInit: begin
                if (O_sdrc_init_done) state_d = StIdle;
            end
            StIdle: begin
                if (refresh_due) begin
                    state_d = StRefresh;
                end else if (req != 2'b00) begin
                    state_d      = StGrant;
                    last_grant_d = (req == 2'b11) ? ~last_grant_q : req[1];
                end
            end
            StGrant: begin
                if (!req[last_grant_q]) state_d = StIdle;
            end
`ifdef SDRAM_ARBITER_REFRESH_EN
            StRefresh: state_d = StRefreshWait;
            StRefreshWait: begin
                gap_d = '0;
                if (O_sdrc_cmd_ack) state_d = StRefreshGap;
            end
            StRefreshGap: begin
                if (gap_q == GapLast) state_d = StIdle;
                else gap_d = gap_q + GapW'(1);
            end
`endif
            default: state_d = StInit;
        endcase
    end

    assign gnt = (state_q != StGrant) ? 2'b00 : (last_grant_q ? 2'b10 : 2'b01);

    always_comb begin
        I_sdrc_cmd_en   = 1'b0;
        I_sdrc_cmd      = 3'b000;
        I_sdrc_addr     = '0;
        I_sdrc_data_len = 8'd0;
        I_sdrc_data     = 32'd0;
        c_cmd_ack       = 2'b00;
        if (state_q == StGrant) begin
            I_sdrc_cmd_en             = c_cmd_en[last_grant_q];
            I_sdrc_cmd                = c_cmd[last_grant_q];
            I_sdrc_addr               = c_addr[last_grant_q];
            I_sdrc_data_len           = c_data_len[last_grant_q];
            I_sdrc_data               = c_data[last_grant_q];
            c_cmd_ack[last_grant_q]   = O_sdrc_cmd_ack;
        end else if (state_q == StRefresh) begin
            I_sdrc_cmd_en = 1'b1;
            I_sdrc_cmd    = 3'b001;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: stimulus queues expected grant/command/ack events,
// a negedge monitor pops and compares them; directed checks cover timing.
module tb_sdram_arbiter;

    localparam int AW = 21;
    localparam logic [1:0] EvGnt = 2'd0;
    localparam logic [1:0] EvCmd = 2'd1;
    localparam logic [1:0] EvAck = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] val;
    } ev_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [1:0]             req = 2'b00;
    logic [1:0]             gnt;
    logic [1:0]             c_cmd_en = 2'b00;
    logic [1:0][2:0]        c_cmd = '0;
    logic [1:0][AW-1:0]     c_addr = '0;
    logic [1:0][7:0]        c_data_len = '0;
    logic [1:0][31:0]       c_data = '0;
    logic [1:0]             c_cmd_ack;
    logic                   I_sdrc_cmd_en;
    logic [2:0]             I_sdrc_cmd;
    logic [AW-1:0]          I_sdrc_addr;
    logic [7:0]             I_sdrc_data_len;
    logic [31:0]            I_sdrc_data;
    logic                   O_sdrc_init_done = 1'b0;
    logic                   O_sdrc_cmd_ack = 1'b0;
    logic                   refresh_overrun;

    int   vectors = 0;
    int   miscompares = 0;
    ev_t  exp_q[$];
    logic mon_en = 1'b0;
    logic [1:0] gnt_prev = 2'b00;

    sdram_arbiter #(
        .RamAddressBitWidth(AW),
        .RefreshInterval(16),
        .RefreshGap(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt),
        .c_cmd_en(c_cmd_en),
        .c_cmd(c_cmd),
        .c_addr(c_addr),
        .c_data_len(c_data_len),
        .c_data(c_data),
        .c_cmd_ack(c_cmd_ack),
        .I_sdrc_cmd_en(I_sdrc_cmd_en),
        .I_sdrc_cmd(I_sdrc_cmd),
        .I_sdrc_addr(I_sdrc_addr),
        .I_sdrc_data_len(I_sdrc_data_len),
        .I_sdrc_data(I_sdrc_data),
        .O_sdrc_init_done(O_sdrc_init_done),
        .O_sdrc_cmd_ack(O_sdrc_cmd_ack),
        .refresh_overrun(refresh_overrun)
    );

    always #5 clk = ~clk;

    // Controller model: acknowledges every command one cycle later.
    always @(posedge clk) O_sdrc_cmd_ack <= I_sdrc_cmd_en & ~rst;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void exp_gnt(input logic [1:0] g);
        exp_q.push_back('{kind: EvGnt, val: {62'd0, g}});
    endfunction

    function automatic void exp_cmd(input logic [2:0] cmd, input logic [AW-1:0] addr,
                                    input logic [7:0] len, input logic [31:0] data);
        exp_q.push_back('{kind: EvCmd, val: {cmd, addr, len, data}});
    endfunction

    function automatic void exp_ack(input logic [1:0] a);
        exp_q.push_back('{kind: EvAck, val: {62'd0, a}});
    endfunction

    task automatic mon_pop(input string name, input logic [1:0] kind, input logic [63:0] val);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: unexpected event kind %0d value 0x%0h", name, kind, val);
        end else begin
            e = exp_q.pop_front();
            chk(name, {kind, val}, {e.kind, e.val});
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (gnt !== gnt_prev) begin
                mon_pop("mon_gnt", EvGnt, {62'd0, gnt});
                gnt_prev = gnt;
            end
            if (I_sdrc_cmd_en === 1'b1) begin
                mon_pop("mon_cmd", EvCmd, {I_sdrc_cmd, I_sdrc_addr, I_sdrc_data_len, I_sdrc_data});
            end
            if (c_cmd_ack !== 2'b00) begin
                mon_pop("mon_ack", EvAck, {62'd0, c_cmd_ack});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (I_sdrc_cmd_en !== 1'b1 && n < 64);
    endtask

    task automatic wait_gnt(input logic [1:0] g, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt !== g && n < 64);
    endtask

    // Granted client i issues one command while the other client also strobes cmd_en.
    task automatic client_cmd(input int i, input logic [2:0] cmd, input logic [AW-1:0] addr,
                              input logic [7:0] len, input logic [31:0] data);
        exp_cmd(cmd, addr, len, data);
        exp_ack(i == 1 ? 2'b10 : 2'b01);
        c_cmd[i] = cmd;           c_cmd[1-i] = 3'b100;
        c_addr[i] = addr;         c_addr[1-i] = 21'h155;
        c_data_len[i] = len;      c_data_len[1-i] = 8'hEE;
        c_data[i] = data;         c_data[1-i] = 32'h5555AAAA;
        c_cmd_en = 2'b11;
        #1;
        chk("cmd_mux", 66'(I_sdrc_cmd), 66'(cmd));
        chk("addr_mux", 66'(I_sdrc_addr), 66'(addr));
        tick();
        c_cmd_en = 2'b00;
        chk("ack_route", 66'(c_cmd_ack), 66'(i == 1 ? 2'b10 : 2'b01));
    endtask

    task automatic reset_mid_burst();
        exp_gnt(2'b00);
        rst = 1'b1;
        tick();
        chk("rst_gnt", 66'(gnt), 66'(2'b00));
        chk("rst_cmd_en", 66'(I_sdrc_cmd_en), 66'(1'b0));
        chk("rst_overrun", 66'(refresh_overrun), 66'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick();
        tick();
        mon_en = 1'b1;
        chk("reset_gnt", 66'(gnt), 66'(2'b00));
        chk("reset_ack", 66'(c_cmd_ack), 66'(2'b00));
        chk("reset_cmd_en", 66'(I_sdrc_cmd_en), 66'(1'b0));
        chk("reset_cmd", 66'(I_sdrc_cmd), 66'(3'b000));
        chk("reset_addr", 66'(I_sdrc_addr), 66'(21'd0));
        chk("reset_overrun", 66'(refresh_overrun), 66'(1'b0));
        rst = 1'b0;
`ifdef SDRAM_ARBITER_REFRESH_EN
        O_sdrc_init_done = 1'b1;
        repeat (3) exp_cmd(3'b001, '0, 8'd0, 32'd0);
        wait_cmd(n);
        chk("refresh_first", 66'({I_sdrc_cmd_en, I_sdrc_cmd}), 66'(4'b1001));
        wait_cmd(n);
        chk("refresh_period_a", 66'(n), 66'(16));
        wait_cmd(n);
        chk("refresh_period_b", 66'(n), 66'(16));
        chk("idle_no_overrun", 66'(refresh_overrun), 66'(1'b0));
        // Refresh issued, then 1 wait cycle + 8 gap cycles before the client is granted.
        exp_gnt(2'b10);
        req = 2'b10;
        wait_gnt(2'b10, n);
        chk("grant_after_gap", 66'(n), 66'(11));
        req = 2'b11;
        exp_gnt(2'b00);
        exp_cmd(3'b001, '0, 8'd0, 32'd0);
        exp_gnt(2'b01);
        repeat (39) tick();
        chk("overrun_set", 66'(refresh_overrun), 66'(1'b1));
        req = 2'b01;
        tick();
        chk("release_gnt", 66'(gnt), 66'(2'b00));
        tick();
        chk("refresh_before_grant", 66'({I_sdrc_cmd_en, I_sdrc_cmd}), 66'(4'b1001));
        wait_gnt(2'b01, n);
        chk("grant_after_refresh", 66'(n), 66'(11));
        client_cmd(0, 3'b010, 21'h0AB, 8'd3, 32'h12345678);
        reset_mid_burst();
        rst = 1'b0;
        req = 2'b00;
`else
        req = 2'b01;
        repeat (20) tick();
        chk("init_hold_gnt", 66'(gnt), 66'(2'b00));
        chk("init_hold_cmd_en", 66'(I_sdrc_cmd_en), 66'(1'b0));
        O_sdrc_init_done = 1'b1;
        exp_gnt(2'b01);
        tick();
        chk("init_to_idle", 66'(gnt), 66'(2'b00));
        tick();
        chk("first_grant", 66'(gnt), 66'(2'b01));
        client_cmd(0, 3'b011, 21'h1A0, 8'h07, 32'hDEADBEEF);
        req = 2'b00; exp_gnt(2'b00); tick();
        chk("release0", 66'(gnt), 66'(2'b00));
        req = 2'b10; exp_gnt(2'b10); tick();
        chk("single_req1", 66'(gnt), 66'(2'b10));
        client_cmd(1, 3'b110, 21'h1FFFFF, 8'hFF, 32'hCAFEF00D);
        req = 2'b00; exp_gnt(2'b00); tick();
        chk("release1", 66'(gnt), 66'(2'b00));
        req = 2'b11; exp_gnt(2'b01); tick();
        chk("rr_both_pick0", 66'(gnt), 66'(2'b01));
        req = 2'b10; exp_gnt(2'b00); exp_gnt(2'b10); tick();
        chk("handover_idle", 66'(gnt), 66'(2'b00));
        tick();
        chk("handover_grant1", 66'(gnt), 66'(2'b10));
        req = 2'b11; tick();
        chk("grant_held", 66'(gnt), 66'(2'b10));
        req = 2'b01; exp_gnt(2'b00); exp_gnt(2'b01); tick();
        chk("handover_idle_b", 66'(gnt), 66'(2'b00));
        tick();
        chk("rr_back_to0", 66'(gnt), 66'(2'b01));
        client_cmd(0, 3'b010, 21'h0AB, 8'd3, 32'h12345678);
        reset_mid_burst();
        rst = 1'b0;
        O_sdrc_init_done = 1'b0;
        repeat (3) tick();
        chk("post_rst_init", 66'(gnt), 66'(2'b00));
        O_sdrc_init_done = 1'b1;
        exp_gnt(2'b01);
        tick();
        tick();
        chk("regrant_after_init", 66'(gnt), 66'(2'b01));
        chk("overrun_tied_off", 66'(refresh_overrun), 66'(1'b0));
        req = 2'b00; exp_gnt(2'b00);
`endif
        repeat (3) tick();
        chk("scoreboard_drained", 66'(exp_q.size()), 66'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
